me_unit: RTL

ME_UNIT -- requirements
Module: me_unit

---
 rtl/me_unit_pkg.sv | 56 +++++
 rtl/me_unit_if.sv | 28 ++
 rtl/me_load_align.sv | 28 ++
 rtl/me_unit.sv | 93 +++++++++
 4 files changed

// File: rtl/me_unit_pkg.sv
// Shared bus widths and packed field layouts for the memory-access pipeline stage.
// The width macros act as the shared header and can be overridden by an earlier definition.
`ifndef EX_to_ME_Bus_Size
`define EX_to_ME_Bus_Size 131
`endif
`ifndef ME_to_WB_Bus_Size
`define ME_to_WB_Bus_Size 125
`endif
`ifndef ME_to_EX_Bus_Size
`define ME_to_EX_Bus_Size 47
`endif

package me_unit_pkg;
   localparam int EX_ME_W = `EX_to_ME_Bus_Size;
   localparam int ME_WB_W = `ME_to_WB_Bus_Size;
   localparam int ME_EX_W = `ME_to_EX_Bus_Size;

   typedef struct packed {
      logic       sign_ext;
      logic       byte_ld;
      logic       half_ld;
      logic [1:0] off;
   } dest_flag_t;

   typedef struct packed {
      logic        excp_en;
      logic [6:0]  excp_num;
      logic [13:0] csr_num;
      logic        csr_we;
      logic [31:0] csr_wvalue;
      dest_flag_t  dest_flag;
      logic [31:0] pc;
      logic [31:0] final_result;
      logic        res_from_mem;
      logic        gr_we;
      logic [4:0]  dest;
   } ex_me_t;

   typedef struct packed {
      logic        excp_en;
      logic [6:0]  excp_num;
      logic [13:0] csr_num;
      logic        csr_we;
      logic [31:0] csr_wvalue;
      logic [31:0] pc;
      logic [31:0] me_result;
      logic        gr_we;
      logic [4:0]  dest;
   } me_wb_t;

   typedef struct packed {
      logic [13:0] csr_num;
      logic        csr_we;
      logic [31:0] csr_wvalue;
   } me_ex_t;
endpackage

// File: rtl/me_unit_if.sv
// Handshake, data-bus, SRAM-return and flush signals around the memory-access stage.
interface me_unit_if;
   logic                            EX_to_ME_Valid;
   logic [me_unit_pkg::EX_ME_W-1:0] EX_to_ME_Bus;
   logic                            ME_Allow_in;
   logic                            ME_to_WB_Valid;
   logic                            WB_Allow_in;
   logic [me_unit_pkg::ME_WB_W-1:0] ME_to_WB_Bus;
   logic [31:0]                     data_sram_rdata;
   logic [4:0]                      ME_dest;
   logic [31:0]                     ME_Forward_Res;
   logic                            ME_to_ID_Sys_op;
   logic [me_unit_pkg::ME_EX_W-1:0] ME_to_EX_Bus;
   logic                            excp_flush;
   logic                            ertn_flush;

   modport master (
      output EX_to_ME_Valid, EX_to_ME_Bus, WB_Allow_in, data_sram_rdata, excp_flush, ertn_flush,
      input  ME_Allow_in, ME_to_WB_Valid, ME_to_WB_Bus, ME_dest, ME_Forward_Res,
             ME_to_ID_Sys_op, ME_to_EX_Bus
   );

   modport slave (
      input  EX_to_ME_Valid, EX_to_ME_Bus, WB_Allow_in, data_sram_rdata, excp_flush, ertn_flush,
      output ME_Allow_in, ME_to_WB_Valid, ME_to_WB_Bus, ME_dest, ME_Forward_Res,
             ME_to_ID_Sys_op, ME_to_EX_Bus
   );
endinterface

// File: rtl/me_load_align.sv
// Load data alignment: picks the addressed byte/half from the fetched word and extends it.
module me_load_align
   import me_unit_pkg::*;
(
   input  logic [31:0] word,
   input  dest_flag_t  dest_flag,
   output logic [31:0] result
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (dest_flag.off)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = dest_flag.off[1] ? word[31:16] : word[15:0];

      if (dest_flag.byte_ld)
         result = {{24{dest_flag.sign_ext & byte_sel[7]}}, byte_sel};
      else if (dest_flag.half_ld)
         result = {{16{dest_flag.sign_ext & half_sel[15]}}, half_sel};
      else
         result = word;
   end
endmodule

// File: rtl/me_unit.sv
// Memory-access pipeline stage: one-entry register, load-data hold buffer for stalls,
// load alignment and forwarding/bypass outputs.
module me_unit
   import me_unit_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   me_unit_if.slave  bus
);
   logic        me_valid;
   logic        held;
   logic [31:0] hold_buf;
   ex_me_t      pipe;

   logic        ready_go;
   logic        flush;
   logic        allow_in;
   logic        load_en;
   logic        capture_en;
   logic [31:0] load_word;
   logic [31:0] aligned;
   logic [31:0] me_result;
   me_wb_t      wb;
   me_ex_t      ex;

   assign ready_go   = 1'b1;
   assign flush      = bus.excp_flush | bus.ertn_flush;
   assign allow_in   = ~me_valid | (ready_go & bus.WB_Allow_in);
   assign load_en    = allow_in & bus.EX_to_ME_Valid;
   assign capture_en = me_valid & pipe.res_from_mem & ~held & ~bus.WB_Allow_in;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         me_valid <= 1'b0;
         pipe     <= '0;
      end else if (flush) begin
         me_valid <= 1'b0;
      end else if (allow_in) begin
         me_valid <= bus.EX_to_ME_Valid;
         if (bus.EX_to_ME_Valid)
            pipe <= ex_me_t'(bus.EX_to_ME_Bus);
      end
   end

   // SRAM rdata is only guaranteed the cycle after the request; freeze it while stalled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         held     <= 1'b0;
         hold_buf <= '0;
      end else if (flush || load_en) begin
         held <= 1'b0;
      end else if (capture_en) begin
         held     <= 1'b1;
         hold_buf <= bus.data_sram_rdata;
      end
   end

   assign load_word = held ? hold_buf : bus.data_sram_rdata;

   me_load_align u_align (
      .word      (load_word),
      .dest_flag (pipe.dest_flag),
      .result    (aligned)
   );

   assign me_result = pipe.res_from_mem ? aligned : pipe.final_result;

   always_comb begin
      wb            = '0;
      wb.excp_en    = pipe.excp_en;
      wb.excp_num   = pipe.excp_num;
      wb.csr_num    = pipe.csr_num;
      wb.csr_we     = pipe.csr_we & me_valid;
      wb.csr_wvalue = pipe.csr_wvalue;
      wb.pc         = pipe.pc;
      wb.me_result  = me_result;
      wb.gr_we      = pipe.gr_we & me_valid & ~pipe.excp_en;
      wb.dest       = pipe.dest;

      ex            = '0;
      ex.csr_num    = pipe.csr_num;
      ex.csr_we     = pipe.csr_we & me_valid;
      ex.csr_wvalue = pipe.csr_wvalue;
   end

   assign bus.ME_Allow_in     = allow_in;
   assign bus.ME_to_WB_Valid  = me_valid & ready_go;
   assign bus.ME_to_WB_Bus    = wb;
   assign bus.ME_to_EX_Bus    = ex;
   assign bus.ME_dest         = (me_valid & pipe.gr_we) ? pipe.dest : 5'd0;
   assign bus.ME_Forward_Res  = me_result;
   assign bus.ME_to_ID_Sys_op = me_valid & pipe.excp_en;
endmodule
